// File: rtl/sdram_responder.sv
// Synthesizable SDRAM-side responder: internal word RAM, fixed-latency read pipeline, sticky error flags.
// Optional protocol checker and proto_error port are compiled in with `define RESPONDER_PROTO_CHECK_EN.
module sdram_responder #(
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_read_en,
  input  logic        sdram_write_en,
  input  logic [25:0] address_sdram,
  input  logic [31:0] writeData_sdram,
  output logic [31:0] data_sdram,
  output logic        sdram_datareadvalid,
  output logic        addr_error
`ifdef RESPONDER_PROTO_CHECK_EN
  ,
  output logic        proto_error
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]             ram [DEPTH];
  logic [ADDR_BITS-1:0]    index;
  logic                    out_of_range;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    addr_error_reg;
  logic [READ_LATENCY-1:0] valid_reg;
  logic [31:0]             data_reg [READ_LATENCY];

  assign index        = address_sdram[ADDR_BITS-1:0];
  assign out_of_range = |address_sdram[25:ADDR_BITS];
  assign wr_accept    = sdram_write_en && !out_of_range;

`ifdef RESPONDER_PROTO_CHECK_EN
  logic prev_read_reg;
  logic proto_error_reg;

  // Only the first cycle of a held read pulse is a request.
  assign rd_accept   = sdram_read_en && !prev_read_reg;
  assign proto_error = proto_error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_read_reg   <= 1'b0;
      proto_error_reg <= 1'b0;
    end else begin
      prev_read_reg <= sdram_read_en;
      if (sdram_read_en && (prev_read_reg || sdram_write_en))
        proto_error_reg <= 1'b1;
    end
  end
`else
  assign rd_accept = sdram_read_en;
`endif

  always_ff @(posedge clk) begin
    if (wr_accept)
      ram[index] <= writeData_sdram;
  end

  // Stage 0 captures the word at the request edge (write-first on a
  // same-cycle write), so later writes cannot disturb an in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        data_reg[i] <= 32'h0;
    end else begin
      valid_reg[0] <= rd_accept;
      if (rd_accept) begin
        if (out_of_range)
          data_reg[0] <= OOR_DATA;
        else if (sdram_write_en)
          data_reg[0] <= writeData_sdram;
        else
          data_reg[0] <= ram[index];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1])
          data_reg[i] <= data_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      addr_error_reg <= 1'b0;
    else if ((sdram_read_en || sdram_write_en) && out_of_range)
      addr_error_reg <= 1'b1;
  end

  // Last stage only loads on a valid, so it holds the previous read word.
  assign data_sdram          = data_reg[READ_LATENCY-1];
  assign sdram_datareadvalid = valid_reg[READ_LATENCY-1];
  assign addr_error          = addr_error_reg;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder at default parameters (READ_LATENCY=2, ADDR_BITS=10).
// Exercises the protocol checker too when RESPONDER_PROTO_CHECK_EN is defined.
module tb_sdram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        addr_error;
`ifdef RESPONDER_PROTO_CHECK_EN
  logic        proto_error;
`endif

  int checks = 0;
  int fails  = 0;

  sdram_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .sdram_read_en       (sdram_read_en),
    .sdram_write_en      (sdram_write_en),
    .address_sdram       (address_sdram),
    .writeData_sdram     (writeData_sdram),
    .data_sdram          (data_sdram),
    .sdram_datareadvalid (sdram_datareadvalid),
    .addr_error          (addr_error)
`ifdef RESPONDER_PROTO_CHECK_EN
    ,
    .proto_error         (proto_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [25:0] a, input logic [31:0] d);
    address_sdram = a; writeData_sdram = d; sdram_write_en = 1'b1;
    tick();
    sdram_write_en = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; sdram_read_en = 1'b0; sdram_write_en = 1'b0;
    address_sdram = '0; writeData_sdram = '0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (data_sdram !== 32'h0 || sdram_datareadvalid !== 1'b0 || addr_error !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got data=%h valid=%b aerr=%b, need 0/0/0",
                 c, data_sdram, sdram_datareadvalid, addr_error);
      end
      tick();
    end
    $display("reset idle done");
  endtask

  task automatic test_write_read();
    do_write(26'd5, 32'h11223344);
    address_sdram = 26'd5; sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0;
    checks++;
    if (sdram_datareadvalid !== 1'b0) begin
      fails++; $display("FAIL wr_rd_early: got valid=%b, need 0", sdram_datareadvalid);
    end
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'h11223344) begin
      fails++; $display("FAIL wr_rd_pulse: got valid=%b data=%h, need 1/11223344", sdram_datareadvalid, data_sdram);
    end
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b0 || data_sdram !== 32'h11223344) begin
      fails++; $display("FAIL wr_rd_hold: got valid=%b data=%h, need 0/11223344", sdram_datareadvalid, data_sdram);
    end
    $display("read addr=5 data=%h", data_sdram);
  endtask

  task automatic test_pipelined();
    logic        exp_v [5];
    logic [31:0] exp_d [5];
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{32'h11223344, 32'hA0, 32'hA1, 32'hA2, 32'hA2};
    for (int i = 0; i < 3; i++) do_write(26'(i), 32'hA0 + 32'(i));
    for (int c = 0; c < 5; c++) begin
      sdram_read_en = (c < 3);
      address_sdram = 26'(c);
      tick();
      checks++;
      if (sdram_datareadvalid !== exp_v[c] || data_sdram !== exp_d[c]) begin
        fails++;
        $display("FAIL pipelined cycle %0d: got valid=%b data=%h, need %b/%h",
                 c, sdram_datareadvalid, data_sdram, exp_v[c], exp_d[c]);
      end
      $display("pipelined cycle %0d valid=%b data=%h", c, sdram_datareadvalid, data_sdram);
    end
    sdram_read_en = 1'b0;
  endtask

  task automatic test_same_cycle_rw();
    do_write(26'd7, 32'h00000001);
    address_sdram = 26'd7; writeData_sdram = 32'hCAFEF00D;
    sdram_write_en = 1'b1; sdram_read_en = 1'b1;
    tick();
    sdram_write_en = 1'b0; sdram_read_en = 1'b0;
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'hCAFEF00D) begin
      fails++; $display("FAIL rw_same: got valid=%b data=%h, need 1/cafef00d", sdram_datareadvalid, data_sdram);
    end
    $display("read+write addr=7 data=%h", data_sdram);
  endtask

  task automatic test_read_hazard();
    address_sdram = 26'd5; sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0; sdram_write_en = 1'b1; writeData_sdram = 32'h00000055;
    tick();
    sdram_write_en = 1'b0;
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'h11223344) begin
      fails++; $display("FAIL hazard_old: got valid=%b data=%h, need 1/11223344", sdram_datareadvalid, data_sdram);
    end
    sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0;
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'h00000055) begin
      fails++; $display("FAIL hazard_new: got valid=%b data=%h, need 1/00000055", sdram_datareadvalid, data_sdram);
    end
    $display("hazard read addr=5 data=%h", data_sdram);
  endtask

  task automatic test_out_of_range();
    checks++;
    if (addr_error !== 1'b0) begin
      fails++; $display("FAIL oor_pre: got aerr=%b, need 0", addr_error);
    end
    address_sdram = 26'h0400; sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0;
    checks++;
    if (addr_error !== 1'b1) begin
      fails++; $display("FAIL oor_flag: got aerr=%b, need 1", addr_error);
    end
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'hDEADBEEF) begin
      fails++; $display("FAIL oor_data: got valid=%b data=%h, need 1/deadbeef", sdram_datareadvalid, data_sdram);
    end
    do_write(26'h0400, 32'h00000099);
    address_sdram = 26'd0; sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0;
    tick();
    checks++;
    if (sdram_datareadvalid !== 1'b1 || data_sdram !== 32'hA0 || addr_error !== 1'b1) begin
      fails++;
      $display("FAIL oor_write_dropped: got valid=%b data=%h aerr=%b, need 1/000000a0/1",
               sdram_datareadvalid, data_sdram, addr_error);
    end
    $display("oor access done, aerr=%b", addr_error);
  endtask

  task automatic test_reset_inflight();
    address_sdram = 26'd5; sdram_read_en = 1'b1;
    tick();
    sdram_read_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (data_sdram !== 32'h0 || sdram_datareadvalid !== 1'b0 || addr_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_inflight: got data=%h valid=%b aerr=%b, need 0/0/0",
               data_sdram, sdram_datareadvalid, addr_error);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (sdram_datareadvalid !== 1'b0) begin
        fails++; $display("FAIL reset_drop cycle %0d: got valid=%b, need 0", c, sdram_datareadvalid);
      end
    end
    $display("reset during read done");
  endtask

  task automatic test_held_read();
    int pulses = 0;
`ifdef RESPONDER_PROTO_CHECK_EN
    int exp_pulses = 1;
    checks++;
    if (proto_error !== 1'b0) begin
      fails++; $display("FAIL proto_pre: got perr=%b, need 0", proto_error);
    end
`else
    int exp_pulses = 3;
`endif
    address_sdram = 26'd2;
    for (int c = 0; c < 7; c++) begin
      sdram_read_en = (c < 3);
      tick();
      if (sdram_datareadvalid === 1'b1) pulses++;
    end
    sdram_read_en = 1'b0;
    checks++;
    if (pulses != exp_pulses || data_sdram !== 32'hA2) begin
      fails++; $display("FAIL held_read: got pulses=%0d data=%h, need %0d/000000a2", pulses, data_sdram, exp_pulses);
    end
`ifdef RESPONDER_PROTO_CHECK_EN
    checks++;
    if (proto_error !== 1'b1) begin
      fails++; $display("FAIL proto_flag: got perr=%b, need 1", proto_error);
    end
`endif
    $display("held read addr=2 pulses=%0d", pulses);
  endtask

  initial begin
    test_reset();
    test_write_read();
`ifndef RESPONDER_PROTO_CHECK_EN
    test_pipelined();
`else
    for (int i = 0; i < 3; i++) do_write(26'(i), 32'hA0 + 32'(i));
`endif
    test_same_cycle_rw();
    test_read_hazard();
    test_out_of_range();
    test_reset_inflight();
    test_held_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
